// File: rtl/cnn_cfg_pkg.sv
// rtl/cnn_cfg_pkg.sv - shared conv layer constants and sequencer state encoding
package cnn_cfg_pkg;

    localparam int K        = 5;
    localparam int OUT_SIZE = 28;
    localparam int OUT_CH   = 6;
    localparam int IN_CH    = 1;
    localparam int N_STEP   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - stepping counter that returns to zero once the next step would reach LIMIT
module wrap_counter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int LIMIT = 2
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    // wrap is qualified by en so counters chain directly: wrap of one is en of the next
    assign wrap = en && (int'(value) + STEP >= LIMIT);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= wrap ? '0 : value + WIDTH'(STEP);
        end
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// rtl/conv_loop_sequencer.sv - nested m/r/c/n/i/j loop index generator for one conv layer pass
module conv_loop_sequencer #(
    parameter int K        = cnn_cfg_pkg::K,
    parameter int OUT_SIZE = cnn_cfg_pkg::OUT_SIZE,
    parameter int OUT_CH   = cnn_cfg_pkg::OUT_CH,
    parameter int IN_CH    = cnn_cfg_pkg::IN_CH,
    parameter int N_STEP   = cnn_cfg_pkg::N_STEP
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        stall,
    output logic        busy,
    output logic        idx_valid,
    output logic [7:0]  m,
    output logic [7:0]  r,
    output logic [7:0]  c,
    output logic [7:0]  n,
    output logic [3:0]  i,
    output logic [3:0]  j,
    output logic        tap_first,
    output logic        tap_last,
    output logic [15:0] pix_addr,
    output logic        done
);

    if (K < 1 || K > 16 || OUT_SIZE < 1 || OUT_SIZE > 255 || OUT_CH < 1 || OUT_CH > 255 ||
        IN_CH < 1 || IN_CH > 255 || N_STEP < 1) begin : g_param_check
        $error("conv_loop_sequencer: layer parameter out of range");
    end

    cnn_cfg_pkg::seq_state_t state;

    logic advance;
    logic wrap_j, wrap_i, wrap_n, wrap_c, wrap_r, wrap_m;

    assign advance = idx_valid && !stall;

    wrap_counter #(.WIDTH(4), .STEP(1), .LIMIT(K)) u_cnt_j (
        .clock(clock), .rst_n(rst_n), .clr(abort), .en(advance), .value(j), .wrap(wrap_j));
    wrap_counter #(.WIDTH(4), .STEP(1), .LIMIT(K)) u_cnt_i (
        .clock(clock), .rst_n(rst_n), .clr(abort), .en(wrap_j), .value(i), .wrap(wrap_i));
    wrap_counter #(.WIDTH(8), .STEP(N_STEP), .LIMIT(IN_CH)) u_cnt_n (
        .clock(clock), .rst_n(rst_n), .clr(abort), .en(wrap_i), .value(n), .wrap(wrap_n));
    wrap_counter #(.WIDTH(8), .STEP(1), .LIMIT(OUT_SIZE)) u_cnt_c (
        .clock(clock), .rst_n(rst_n), .clr(abort), .en(wrap_n), .value(c), .wrap(wrap_c));
    wrap_counter #(.WIDTH(8), .STEP(1), .LIMIT(OUT_SIZE)) u_cnt_r (
        .clock(clock), .rst_n(rst_n), .clr(abort), .en(wrap_c), .value(r), .wrap(wrap_r));
    wrap_counter #(.WIDTH(8), .STEP(1), .LIMIT(OUT_CH)) u_cnt_m (
        .clock(clock), .rst_n(rst_n), .clr(abort), .en(wrap_r), .value(m), .wrap(wrap_m));

    // Every counter wraps on the final advance, so DONE sees all-zero indices without a clear
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= cnn_cfg_pkg::ST_IDLE;
            busy      <= 1'b0;
            idx_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                cnn_cfg_pkg::ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state     <= cnn_cfg_pkg::ST_RUN;
                        busy      <= 1'b1;
                        idx_valid <= 1'b1;
                    end
                end
                cnn_cfg_pkg::ST_RUN: begin
                    if (abort) begin
                        state     <= cnn_cfg_pkg::ST_IDLE;
                        busy      <= 1'b0;
                        idx_valid <= 1'b0;
                    end else if (wrap_m) begin
                        state     <= cnn_cfg_pkg::ST_DONE;
                        busy      <= 1'b0;
                        idx_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= cnn_cfg_pkg::ST_IDLE;
                    busy      <= 1'b0;
                    idx_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign tap_first = idx_valid && (n == 8'd0) && (i == 4'd0) && (j == 4'd0);
    assign tap_last  = idx_valid && (int'(n) + N_STEP >= IN_CH) &&
                       (i == 4'(K - 1)) && (j == 4'(K - 1));

    assign pix_addr = 16'(m) * 16'(OUT_SIZE * OUT_SIZE) + 16'(r) * 16'(OUT_SIZE) + 16'(c);

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// tb/tb_conv_loop_sequencer.sv - scoreboard bench for conv_loop_sequencer at default and small configs
module tb_conv_loop_sequencer;

    logic clock;
    logic rst_n;

    logic d_start, d_abort, d_stall;
    logic d_busy, d_idx_valid, d_tap_first, d_tap_last, d_done;
    logic [7:0] d_m, d_r, d_c, d_n;
    logic [3:0] d_i, d_j;
    logic [15:0] d_pix_addr;

    logic s_start, s_abort, s_stall;
    logic s_busy, s_idx_valid, s_tap_first, s_tap_last, s_done;
    logic [7:0] s_m, s_r, s_c, s_n;
    logic [3:0] s_i, s_j;
    logic [15:0] s_pix_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sq[$];
    logic [63:0] d_tuple, s_tuple;

    int adv, n_last, n_done, n_valid, stall_left;
    bit stalled_once;

    assign d_tuple = {6'd0, d_m, d_r, d_c, d_n, d_i, d_j, d_tap_first, d_tap_last, d_pix_addr};
    assign s_tuple = {6'd0, s_m, s_r, s_c, s_n, s_i, s_j, s_tap_first, s_tap_last, s_pix_addr};

    conv_loop_sequencer dut (
        .clock(clock), .rst_n(rst_n), .start(d_start), .abort(d_abort), .stall(d_stall),
        .busy(d_busy), .idx_valid(d_idx_valid), .m(d_m), .r(d_r), .c(d_c), .n(d_n),
        .i(d_i), .j(d_j), .tap_first(d_tap_first), .tap_last(d_tap_last),
        .pix_addr(d_pix_addr), .done(d_done));

    conv_loop_sequencer #(.K(2), .OUT_SIZE(3), .OUT_CH(2), .IN_CH(1), .N_STEP(4)) dut_s (
        .clock(clock), .rst_n(rst_n), .start(s_start), .abort(s_abort), .stall(s_stall),
        .busy(s_busy), .idx_valid(s_idx_valid), .m(s_m), .r(s_r), .c(s_c), .n(s_n),
        .i(s_i), .j(s_j), .tap_first(s_tap_first), .tap_last(s_tap_last),
        .pix_addr(s_pix_addr), .done(s_done));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(int pm, int pr, int pc, int pn, int pi, int pj,
                                         bit pf, bit pl, int pix);
        return {6'd0, 8'(pm), 8'(pr), 8'(pc), 8'(pn), 4'(pi), 4'(pj), pf, pl, 16'(pix)};
    endfunction

    // Default layer: 5x5 kernel, 28x28 output, 6 channels, single n group
    function automatic logic [63:0] exp_def(int a);
        int ej, ei, ec, er, em;
        ej = a % 5;
        ei = (a / 5) % 5;
        ec = (a / 25) % 28;
        er = (a / 700) % 28;
        em = a / 19600;
        return pack(em, er, ec, 0, ei, ej, (ei == 0 && ej == 0), (ei == 4 && ej == 4),
                    em * 784 + er * 28 + ec);
    endfunction

    initial begin
        rst_n = 1'b0;
        d_start = 0; d_abort = 0; d_stall = 0;
        s_start = 0; s_abort = 0; s_stall = 0;
        repeat (3) @(negedge clock);
        check("rst_tuple", d_tuple, 64'd0);
        check("rst_flags", {d_busy, d_idx_valid, d_done}, 3'b000);
        check("rst_s_tuple", s_tuple, 64'd0);
        rst_n = 1'b1;
        @(negedge clock);

        // Small config pass with a 3-cycle stall and a stray start mid-pass
        for (int pm = 0; pm < 2; pm++)
            for (int pr = 0; pr < 3; pr++)
                for (int pc = 0; pc < 3; pc++)
                    for (int pn = 0; pn < 1; pn += 4)
                        for (int pi = 0; pi < 2; pi++)
                            for (int pj = 0; pj < 2; pj++)
                                sq.push_back(pack(pm, pr, pc, pn, pi, pj,
                                    (pn == 0 && pi == 0 && pj == 0),
                                    (pn + 4 >= 1 && pi == 1 && pj == 1),
                                    pm * 9 + pr * 3 + pc));
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        adv = 0; n_last = 0; n_done = 0; n_valid = 0; stall_left = 0; stalled_once = 0;
        for (int cyc = 0; cyc < 200 && n_done == 0; cyc++) begin
            if (s_idx_valid) begin
                n_valid++;
                if (sq.size() == 0) check("s_extra_valid", 1, 0);
                else check("s_tuple", s_tuple, sq[0]);
                if (s_tap_last) n_last++;
                s_start = (adv == 20);
                if (adv == 6 && !stalled_once) begin
                    s_stall = 1'b1;
                    stall_left = 3;
                    stalled_once = 1;
                end else if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) s_stall = 1'b0;
                end
                if (!s_stall && sq.size() > 0) begin
                    void'(sq.pop_front());
                    adv++;
                end
            end
            if (s_done) begin
                n_done++;
                check("s_done_valid", s_idx_valid, 0);
                check("s_done_queue", sq.size(), 0);
                check("s_done_tuple", s_tuple, 64'd0);
            end
            @(negedge clock);
        end
        check("s_done_count", n_done, 1);
        check("s_adv_count", adv, 72);
        check("s_valid_count", n_valid, 75);
        check("s_last_count", n_last, 18);
        check("s_after_done", {s_done, s_busy, s_idx_valid}, 3'b000);

        // Default pass A: latency, first taps, wraps, abort at advance 100
        d_start = 1'b1;
        @(negedge clock);
        d_start = 1'b0;
        check("d_first_valid", {d_busy, d_idx_valid}, 2'b11);
        for (int a = 0; a <= 100; a++) begin
            if (a == 0 || a == 1 || a == 25 || a == 100)
                check($sformatf("dA_tuple_%0d", a), d_tuple, exp_def(a));
            if (a == 100) d_abort = 1'b1;
            @(negedge clock);
        end
        d_abort = 1'b0;
        check("d_abort_flags", {d_busy, d_idx_valid, d_done}, 3'b000);
        check("d_abort_tuple", d_tuple, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("d_abort_no_done", d_done, 0);
        end

        // Default pass B: restart from zero, ignored start, row wrap, async reset
        d_start = 1'b1;
        @(negedge clock);
        d_start = 1'b0;
        for (int a = 0; a <= 750; a++) begin
            if (a == 0 || a == 11 || a == 700)
                check($sformatf("dB_tuple_%0d", a), d_tuple, exp_def(a));
            if (a == 700) check("dB_pix_700", d_pix_addr, 28);
            if (a == 11) check("dB_busy_11", {d_busy, d_idx_valid, d_done}, 3'b110);
            d_start = (a == 10);
            if (a < 750) @(negedge clock);
        end
        #2 rst_n = 1'b0;
        #1;
        check("d_async_tuple", d_tuple, 64'd0);
        check("d_async_flags", {d_busy, d_idx_valid, d_done}, 3'b000);
        @(negedge clock);
        check("d_async_hold", {d_busy, d_idx_valid, d_done}, 3'b000);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
